// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link parameters.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEF = 10417;
    localparam int UART_DATA_BITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Even-parity bit for a data byte
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx pin (resets to idle-high),
// plus a falling-edge flag built from the synchronized value and its previous sample.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default; defining UART_RX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit and enables the parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    rx_state_e            state_q;
    logic [CW-1:0]        baud_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 frame_err_q;
    logic                 par_ok_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    // Receive FSM with registered strobes; every sample lands at mid-bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            par_ok_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    baud_cnt_q <= '0;
                    bit_idx_q  <= 3'd0;
                    par_ok_q   <= 1'b1;
                    if (rx_en && rx_fall) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt_q == HALF_CNT) begin
                        baud_cnt_q <= '0;
                        if (rx_s) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_q == FULL_CNT) begin
                        baud_cnt_q         <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_cnt_q == FULL_CNT) begin
                        baud_cnt_q <= '0;
                        par_ok_q   <= (rx_s == even_parity(shift_q));
                        state_q    <= ST_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_cnt_q == FULL_CNT) begin
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                        end else if (par_ok_q) begin
                            data_q <= shift_q;
                            done_q <= 1'b1;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= 1'b1;
`else
                            done_q <= 1'b0;
`endif
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit time; frames are driven on the
// falling clock edge and strobes are counted by a negedge monitor.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int last_done_cyc = 0;
    int fall_cyc = 0;
    logic busy_seen = 1'b0;
    int done_b, ferr_b, perr_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_en      (rx_en),
        .rx         (rx),
        .data       (data),
        .done       (done),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        done_b    = done_cnt;
        ferr_b    = ferr_cnt;
        perr_b    = perr_cnt;
        busy_seen = 1'b0;
    endtask

    // Called on a falling edge; rst_bit >= 0 pulses reset at the start of that data bit
    task automatic send_frame(input logic [7:0] b, input logic par_b, input logic stop_b,
                              input int rst_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                rst_n = 1'b0;
                rx_en = 1'b0;
                idle(1);
                rst_n = 1'b1;
                idle(1);
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                idle(CPB - 2);
            end else begin
                idle(CPB);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        idle(CPB);
`else
        if (par_b) rx = 1'b1;
`endif
        rx = stop_b;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic verify(input string tag, input logic [7:0] exp_data, input int exp_done,
                          input int exp_ferr, input int exp_perr);
        chk({tag, "_data"}, {24'd0, data}, {24'd0, exp_data});
        chk({tag, "_done"}, done_cnt - done_b, exp_done);
        chk({tag, "_ferr"}, ferr_cnt - ferr_b, exp_ferr);
        chk({tag, "_perr"}, perr_cnt - perr_b, exp_perr);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] vec [4] = '{8'hA5, 8'h00, 8'hFF, 8'hF0};
    int lat;

    initial begin
        rst_n = 1'b0;
        rx_en = 1'b1;
        rx    = 1'b1;
        idle(4);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // 1: plain frames
        for (int k = 0; k < 4; k++) begin
            snap();
            send_frame(vec[k], ^vec[k], 1'b1, -1);
            if (k == 0) begin
                lat = last_done_cyc - fall_cyc;
                chk("done_latency", (lat >= 154 && lat <= 156) ? 32'd155 : lat, 32'd155);
            end
            idle(CPB);
            verify($sformatf("frame%0d", k), vec[k], 1, 0, 0);
        end

        // 2: back-to-back frames, no idle gap
        snap();
        send_frame(8'h3C, ^8'h3C, 1'b1, -1);
        chk("b2b_first_data", {24'd0, data}, 32'h3C);
        chk("b2b_first_done", done_cnt - done_b, 32'd1);
        send_frame(8'hC3, ^8'hC3, 1'b1, -1);
        idle(CPB);
        verify("b2b", 8'hC3, 2, 0, 0);

        // 3: glitch shorter than half a bit
        snap();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(2 * CPB);
        chk("false_start_busy_seen", {31'd0, busy_seen}, 32'd1);
        verify("false_start", 8'hC3, 0, 0, 0);

        // 4: bad stop bit, then line held low in idle must not restart
        snap();
        send_frame(8'h5A, ^8'h5A, 1'b0, -1);
        rx = 1'b0;
        idle(3 * CPB);
        rx = 1'b1;
        idle(CPB);
        verify("bad_stop", 8'hC3, 0, 1, 0);

        // 5: reset during bit 4, then a clean frame
        snap();
        send_frame(8'h81, ^8'h81, 1'b1, 4);
        idle(2 * CPB);
        verify("aborted", 8'h00, 0, 0, 0);
        rx_en = 1'b1;
        snap();
        send_frame(8'h81, ^8'h81, 1'b1, -1);
        idle(CPB);
        verify("after_rst", 8'h81, 1, 0, 0);

        // rx_en low blocks start detection
        rx_en = 1'b0;
        snap();
        send_frame(8'h55, ^8'h55, 1'b1, -1);
        idle(CPB);
        verify("rx_en_off", 8'h81, 0, 0, 0);
        rx_en = 1'b1;

`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad
        snap();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(CPB);
        verify("par_good", 8'h07, 1, 0, 0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1, -1);
        idle(CPB);
        verify("par_bad", 8'h07, 0, 0, 1);
`else
        snap();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(CPB);
        verify("frame_07", 8'h07, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
